// File: rtl/nexys_starship_pkg.sv
// Shared constants and helper functions for the Nexys Starship spawn generator.
// Holds LFSR geometry, per-channel seed derivation and the LFSR step function.
package nexys_starship_pkg;

    localparam int LFSR_W = 16;

    // Fibonacci taps 16,14,13,11 expressed as zero-based bit indices
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    localparam logic [LFSR_W-1:0] SEED_STRIDE = 16'h2F1D;
    localparam logic [LFSR_W-1:0] ZERO_SUB    = 16'h0001;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        logic fb;
        fb = l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
        return {l[LFSR_W-2:0], fb};
    endfunction

    // Rotate the base seed by the channel index and mix in a stride multiple so
    // neighbouring lanes start far apart; zero is replaced because it locks the LFSR.
    function automatic logic [LFSR_W-1:0] derive_seed(input logic [LFSR_W-1:0] s,
                                                      input logic [3:0]        idx);
        logic [2*LFSR_W-1:0] dbl;
        logic [LFSR_W-1:0]   rot;
        logic [LFSR_W-1:0]   prod;
        logic [LFSR_W-1:0]   seed;
        dbl  = {s, s} << idx;
        rot  = dbl[2*LFSR_W-1:LFSR_W];
        prod = {12'd0, idx} * SEED_STRIDE;
        seed = rot ^ prod;
        if (seed == '0) begin
            seed = ZERO_SUB;
        end
        return seed;
    endfunction

endpackage

// File: rtl/nexys_starship_prng_ch.sv
// One spawn lane: free-running 16-bit LFSR, threshold compare and cooldown timer.
// Priority at each edge is seed reload, then run, then freeze.
module nexys_starship_prng_ch
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = 16'h0001,
    parameter logic [7:0]  COOLDOWN   = 8'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        run,
    input  logic        seed_load,
    input  logic [15:0] load_seed,
    input  logic        en,
    input  logic [7:0]  threshold,
    output logic [15:0] lfsr,
    output logic        spawn
);

    logic [7:0] cool;
    logic       hit;

    assign hit = en && (cool == 8'd0) && (lfsr[7:0] < threshold);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr  <= RESET_SEED;
            cool  <= 8'd0;
            spawn <= 1'b0;
        end else if (seed_load) begin
            lfsr  <= load_seed;
            cool  <= 8'd0;
            spawn <= 1'b0;
        end else if (run) begin
            // Disabled lanes keep stepping so enabling one later does not replay history
            lfsr  <= lfsr_next(lfsr);
            spawn <= hit;
            if (hit) begin
                cool <= COOLDOWN;
            end else if (cool != 8'd0) begin
                cool <= cool - 8'd1;
            end
        end else begin
            spawn <= 1'b0;
        end
    end

endmodule

// File: rtl/nexys_starship_spawn_prng.sv
// Multi-lane spawn generator: one independent PRNG channel per screen lane,
// with shared threshold/run/reseed control and a debug view of any lane's LFSR.
module nexys_starship_spawn_prng
    import nexys_starship_pkg::*;
#(
    parameter int          NUM_CH    = 8,
    parameter int          COOLDOWN  = 4,
    parameter logic [15:0] BASE_SEED = 16'hACE1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              run,
    input  logic [7:0]        threshold,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              seed_load,
    input  logic [15:0]       seed_in,
    output logic [NUM_CH-1:0] spawn,
    input  logic [3:0]        dbg_sel,
    output logic [15:0]       dbg_lfsr
);

    logic [15:0] lfsr_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [15:0] CH_RESET_SEED = derive_seed(BASE_SEED, 4'(i));

        logic [15:0] ch_load_seed;
        assign ch_load_seed = derive_seed(seed_in, 4'(i));

        nexys_starship_prng_ch #(
            .RESET_SEED (CH_RESET_SEED),
            .COOLDOWN   (8'(COOLDOWN))
        ) u_ch (
            .Clk       (Clk),
            .Reset     (Reset),
            .run       (run),
            .seed_load (seed_load),
            .load_seed (ch_load_seed),
            .en        (en_mask[i]),
            .threshold (threshold),
            .lfsr      (lfsr_arr[i]),
            .spawn     (spawn[i])
        );
    end

    // Out-of-range selections read as zero, which no running LFSR can hold
    always_comb begin
        dbg_lfsr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dbg_sel == 4'(i)) begin
                dbg_lfsr = lfsr_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_nexys_starship_spawn_prng.sv
// Directed bench for the spawn generator: a behavioural lane model feeds an
// expected-spawn queue that is compared one edge after each stimulus step.
module tb_nexys_starship_spawn_prng;

    localparam int          NUM_CH    = 8;
    localparam int          COOLDOWN  = 4;
    localparam logic [15:0] BASE_SEED = 16'hACE1;

    logic              Clk;
    logic              Reset;
    logic              run;
    logic [7:0]        threshold;
    logic [NUM_CH-1:0] en_mask;
    logic              seed_load;
    logic [15:0]       seed_in;
    logic [NUM_CH-1:0] spawn;
    logic [3:0]        dbg_sel;
    logic [15:0]       dbg_lfsr;

    nexys_starship_spawn_prng #(
        .NUM_CH    (NUM_CH),
        .COOLDOWN  (COOLDOWN),
        .BASE_SEED (BASE_SEED)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .run       (run),
        .threshold (threshold),
        .en_mask   (en_mask),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .spawn     (spawn),
        .dbg_sel   (dbg_sel),
        .dbg_lfsr  (dbg_lfsr)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- scoreboard state ----------------
    logic [NUM_CH-1:0] exp_q [$];
    logic [15:0]       m_lfsr  [NUM_CH];
    logic [7:0]        m_cool  [NUM_CH];
    int                last_sp [NUM_CH];
    int                sp_cnt  [NUM_CH];
    int                n_chk;
    int                n_fail;
    int                cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_seed(input logic [15:0] s, input int idx);
        logic [15:0] v;
        logic [31:0] p;
        v = s;
        for (int k = 0; k < idx % 16; k++) v = {v[14:0], v[15]};
        p = idx * 32'h2F1D;
        v = v ^ p[15:0];
        if (v == 16'h0000) v = 16'h0001;
        return v;
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic model_reset(input logic [15:0] s);
        for (int i = 0; i < NUM_CH; i++) begin
            m_lfsr[i]  = m_seed(s, i);
            m_cool[i]  = 8'd0;
            last_sp[i] = -1;
        end
    endtask

    // One clock: predict, push, advance, pop and compare.
    task automatic tick();
        logic [NUM_CH-1:0] e;
        logic [15:0]       nl [NUM_CH];
        logic [7:0]        nc [NUM_CH];
        logic [NUM_CH-1:0] got_exp;
        logic [15:0]       dexp;
        e = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nl[i] = m_lfsr[i];
            nc[i] = m_cool[i];
            if (seed_load) begin
                nl[i] = m_seed(seed_in, i);
                nc[i] = 8'd0;
            end else if (run) begin
                e[i]  = en_mask[i] && (m_cool[i] == 8'd0) && (m_lfsr[i][7:0] < threshold);
                nl[i] = m_step(m_lfsr[i]);
                if (e[i])                  nc[i] = 8'(COOLDOWN);
                else if (m_cool[i] != 8'd0) nc[i] = m_cool[i] - 8'd1;
            end
        end
        if (seed_load) begin
            for (int i = 0; i < NUM_CH; i++) last_sp[i] = -1;
        end
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            m_lfsr[i] = nl[i];
            m_cool[i] = nc[i];
        end
        got_exp = exp_q.pop_front();
        chk("spawn", 32'(spawn), 32'(got_exp));
        dexp = (int'(dbg_sel) < NUM_CH) ? m_lfsr[dbg_sel] : 16'h0000;
        chk("dbg_lfsr", 32'(dbg_lfsr), 32'(dexp));
        for (int i = 0; i < NUM_CH; i++) begin
            if (spawn[i]) begin
                if (last_sp[i] >= 0) chk("spacing", 32'(cyc - last_sp[i] >= COOLDOWN + 1), 32'd1);
                last_sp[i] = cyc;
                sp_cnt[i]++;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int tot;
        n_chk = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < NUM_CH; i++) sp_cnt[i] = 0;
        Reset = 1'b1; run = 1'b0; threshold = 8'd0; en_mask = '1;
        seed_load = 1'b0; seed_in = 16'h0000; dbg_sel = 4'd0;
        model_reset(BASE_SEED);

        // 1: reset state and first LFSR step
        #2;
        chk("rst_spawn", 32'(spawn), 32'd0);
        chk("rst_dbg", 32'(dbg_lfsr), 32'h0000ACE1);
        #10;
        Reset = 1'b0;
        run = 1'b1;
        tick();
        chk("first_step", 32'(dbg_lfsr), 32'h000059C3);

        // 2: threshold 0 never fires, then 255 fires on every lane with spacing
        tot = 0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (spawn != '0) tot++;
        end
        chk("thr0_silent", 32'(tot), 32'd0);
        threshold = 8'd255;
        for (int i = 0; i < NUM_CH; i++) sp_cnt[i] = 0;
        for (int k = 0; k < 100; k++) tick();
        for (int i = 0; i < NUM_CH; i++) chk("thr255_fires", 32'(sp_cnt[i] > 0), 32'd1);

        // 3: zero seed substitution and cleared state
        seed_in = 16'h0000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("zero_seed", 32'(dbg_lfsr), 32'h00000001);
        chk("load_clears_spawn", 32'(spawn), 32'd0);
        threshold = 8'd0;
        tick();
        chk("zero_seed_step", 32'(dbg_lfsr), 32'h00000002);

        // 4: maximal period from seed 1
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (dbg_lfsr !== 16'h0001 && n < 70000);
        chk("period", 32'(n), 32'd65535);

        // 5: freeze in the middle of a cooldown
        threshold = 8'd255;
        n = 0;
        do begin
            tick();
            n++;
        end while (spawn[0] !== 1'b1 && n < 20);
        chk("t5_spawn_found", 32'(spawn[0]), 32'd1);
        run = 1'b0;
        begin
            logic [15:0] frozen;
            frozen = m_lfsr[0];
            for (int k = 0; k < 10; k++) begin
                tick();
                chk("freeze_dbg", 32'(dbg_lfsr), 32'(frozen));
                chk("freeze_spawn", 32'(spawn), 32'd0);
            end
        end
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("resume_cooldown", 32'(spawn[0]), 32'd0);
        end
        for (int k = 0; k < 6; k++) tick();

        // masking keeps a running cooldown counting
        en_mask = 8'b1111_1110;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("masked_lane", 32'(spawn[0]), 32'd0);
        end
        en_mask = '1;

        // 6: reload wins over a pending hit
        n = 0;
        begin
            logic pend;
            pend = 1'b0;
            while (!pend && n < 20) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (m_cool[i] == 8'd0 && m_lfsr[i][7:0] < threshold) pend = 1'b1;
                if (!pend) begin
                    tick();
                    n++;
                end
            end
            chk("t6_hit_pending", 32'(pend), 32'd1);
        end
        seed_in = 16'h1234; seed_load = 1'b1; run = 1'b1;
        tick();
        seed_load = 1'b0; run = 1'b0;
        chk("load_beats_run", 32'(spawn), 32'd0);
        for (int i = 0; i < NUM_CH; i++) begin
            dbg_sel = 4'(i);
            tick();
            chk("reload_seed", 32'(dbg_lfsr), 32'(m_seed(16'h1234, i)));
        end
        dbg_sel = 4'd12;
        tick();
        chk("dbg_out_of_range", 32'(dbg_lfsr), 32'd0);
        dbg_sel = 4'd0;

        // async reset while spawns are active
        run = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (spawn === '0 && n < 20);
        chk("t6_spawn_active", 32'(spawn != '0), 32'd1);
        Reset = 1'b1;
        #1;
        chk("async_reset_spawn", 32'(spawn), 32'd0);
        chk("async_reset_dbg", 32'(dbg_lfsr), 32'h0000ACE1);
        model_reset(BASE_SEED);
        #3;
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nexys_starship_spawn_prng.md
Name: nexys_starship_spawn_prng

Overview:
Multi-channel pseudo-random spawn generator for Nexys Starship. It is the parametrised successor to the fixed four-counter top/bottom generator. Each channel runs an independent 16-bit maximal-length LFSR, compares a sample against a runtime probability threshold, and emits a registered one-cycle spawn flag. A per-channel cooldown, channel enable mask, run/freeze control and runtime reseed are included. It feeds the game FSM's obstacle/enemy spawn logic, with one channel per screen lane.

Parameters:
NUM_CH, 8, number of independent channels (1..16).
COOLDOWN, 4, cycles a channel is suppressed after a spawn (0..255; 0 means no suppression).
BASE_SEED, 16'hACE1, reset seed for channel 0; the other channels derive from it.

Ports:
Clk  in  1  system clock, all state on rising edge.
Reset  in  1  asynchronous, active-high reset.
run  in  1  1 = LFSRs advance and spawns are evaluated; 0 = freeze.
threshold  in  8  spawn probability numerator; a spawn fires when sample < threshold.
en_mask  in  NUM_CH  per-channel enable.
seed_load  in  1  one-cycle pulse that reloads all channel LFSRs from seed_in.
seed_in  in  16  base seed used when seed_load=1.
spawn  out  NUM_CH  registered one-cycle spawn flags.
dbg_sel  in  4  channel selected for the debug readout (only values below NUM_CH are meaningful).
dbg_lfsr  out  16  combinational view of the selected channel's LFSR state (0 if dbg_sel >= NUM_CH).

Behaviour:
- Seed derivation: seed_i = rotl16(S, i mod 16) XOR trunc16(i * 16'h2F1D).
  - S = BASE_SEED at reset; S = seed_in on seed_load.
  - If seed_i == 0, substitute 16'h0001. Channel 0 seed therefore equals S, or 1 if S = 0.
- LFSR step (Fibonacci, taps 16,14,13,11): fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}. Period is 65535. Zero is unreachable.
- Sample = l[7:0] of the current (pre-step) state. Comparison is unsigned and strict:
  - threshold 0 never fires.
  - threshold 255 fires for every sample except 255.
- Reset (async): lfsr_i <= seed_i from BASE_SEED; cool_i <= 0; spawn <= 0.
- Priority per rising edge: seed_load > run=1 > run=0.
- seed_load=1 (regardless of run):
  - lfsr_i <= seed_i from seed_in.
  - cool_i <= 0.
  - spawn <= 0.
- run=1, seed_load=0, for each channel i:
  - hit_i = en_mask[i] & (cool_i == 0) & (l_i[7:0] < threshold).
  - spawn[i] <= hit_i.
  - lfsr_i <= next(l_i). Disabled channels still advance.
  - cool_i <= hit_i ? COOLDOWN : (cool_i != 0 ? cool_i - 1 : 0).
- run=0, seed_load=0: lfsr_i and cool_i hold; spawn <= 0.
- Latency: spawn reflects the LFSR state and inputs sampled at the same edge, and is visible one cycle after that sample.
- Spacing: with COOLDOWN = C > 0, two spawns on one channel are at least C+1 cycles apart. With C = 0, spawns may occur on consecutive cycles.
- Freeze: run frozen mid-cooldown preserves cool_i, so cooldown resumes exactly where it stopped.
- Masking: clearing en_mask[i] blocks new spawns but does not clear an active cooldown; the cooldown keeps counting down.
- Threshold and en_mask changes take effect on the next edge; there is no internal staging.
- Cooldown counter width is 8 bits. No overflow is possible.

Decomposition:
- Package nexys_starship_pkg holds:
  - LFSR_W = 16.
  - Tap positions.
  - SEED_STRIDE = 16'h2F1D.
  - ZERO_SUB = 16'h0001.
  - Seed-derivation function.
  - LFSR next-state function.
- Sub-module nexys_starship_prng_ch contains one channel: LFSR, compare and cooldown. It is instantiated NUM_CH times via generate. The top level holds seed derivation, the debug mux and the spawn vector.

Test Plan:
1. Reset with BASE_SEED=16'hACE1: spawn=0; dbg_sel=0 gives dbg_lfsr=16'hACE1. After one run cycle, dbg_lfsr=16'h59C3 (fb = 1^1^0^1 = 1).
2. threshold=0, run=1, en_mask all ones, 2000 cycles -> spawn stays 0. Then threshold=255, COOLDOWN=4 -> every channel spawns, and no two spawns on a channel are closer than 5 cycles.
3. seed_load with seed_in=16'h0000 -> channel 0 LFSR = 16'h0001. After one run cycle = 16'h0002. All spawns and cooldowns cleared.
4. Period check, channel 0 from seed 16'h0001, run=1 -> LFSR first returns to 16'h0001 after exactly 65535 cycles.
5. Freeze mid-cooldown: spawn at cycle t, run=0 for 10 cycles, then run=1 -> no spawn on that channel until 4 run-cycles have elapsed. During the freeze, spawn=0 and dbg_lfsr is constant.
6. Simultaneous seed_load=1 and run=1 while a hit is pending -> spawn=0 next cycle and LFSRs equal the derived seeds (seed_load wins). Async Reset asserted mid-run -> spawn=0 immediately, without waiting for a clock edge.
